// File: rtl/instr_feeder.sv
// Instruction feeder: a 32x16 program memory sequenced into a processor one word
// at a time, with mvi immediates, halt, stop handshake and a completion watchdog.
module instr_feeder (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Start,
    input  logic        Stop,
    input  logic        LdEn,
    input  logic [4:0]  LdAddr,
    input  logic [15:0] LdData,
    input  logic        Done,
    output logic [15:0] DIN,
    output logic        Run,
    output logic [4:0]  PC,
    output logic        Busy,
    output logic        Halted,
    output logic        Err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_IMM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [2:0] WD_LAST = 3'd5;

    function automatic logic [2:0] opcode_f(input logic [15:0] word);
        return word[8:6];
    endfunction

    state_e      state_q, state_d;
    logic [4:0]  pc_q, pc_d;
    logic [2:0]  wd_q, wd_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [15:0] mem_q [32];
    logic [15:0] mem_d [32];
    logic [15:0] word_s;

    assign word_s = mem_q[pc_q];

    // Program-memory write path; loads are locked out while an instruction is in flight
    always_comb begin
        mem_d = mem_q;
        if (LdEn && !busy_q) begin
            mem_d[LdAddr] = LdData;
        end else begin
            mem_d = mem_q;
        end
    end

    // Program memory has no reset so a loaded program survives Resetn
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    // Next-state, PC and watchdog logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (Start) begin
                    state_d = ST_ISSUE;
                    pc_d    = 5'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ISSUE: begin
                // Done is ignored here: the processor is only loading its IR
                case (opcode_f(word_s))
                    OP_HALT: state_d = ST_HALT;
                    OP_MVI: begin
                        state_d = ST_IMM;
                        pc_d    = pc_q + 5'd1;
                    end
                    default: begin
                        state_d = ST_WAIT;
                        pc_d    = pc_q + 5'd1;
                    end
                endcase
            end
            ST_IMM: begin
                pc_d = pc_q + 5'd1;
                if (Done) begin
                    state_d = Stop ? ST_IDLE : ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Done) begin
                    state_d = Stop ? ST_IDLE : ST_ISSUE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    wd_d = wd_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = 5'd0;
                wd_d    = 3'd0;
            end
        endcase

        // Any fresh entry into IMM or WAIT restarts the watchdog
        if (((state_d == ST_IMM) || (state_d == ST_WAIT)) && (state_d != state_q)) begin
            wd_d = 3'd0;
        end else begin
            wd_d = wd_d;
        end

        busy_d   = (state_d == ST_ISSUE) || (state_d == ST_IMM) || (state_d == ST_WAIT);
        halted_d = (state_d == ST_HALT);
        err_d    = (state_d == ST_ERROR);
    end

    // State register; status flags are flopped from the next state so they never glitch
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            pc_q     <= 5'd0;
            wd_q     <= 3'd0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Word presented to the processor: live memory read in ISSUE and IMM, zero otherwise
    always_comb begin
        if ((state_q == ST_ISSUE) || (state_q == ST_IMM)) begin
            DIN = word_s;
        end else begin
            DIN = 16'h0000;
        end
    end

    assign Run    = busy_q;
    assign Busy   = busy_q;
    assign Halted = halted_q;
    assign Err    = err_q;
    assign PC     = pc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: mvi/halt sequencing, stop, watchdog, PC wrap,
// load lockout and reset behaviour, checked against hand-computed values.
module tb_instr_feeder;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic        Stop;
    logic        LdEn;
    logic [4:0]  LdAddr;
    logic [15:0] LdData;
    logic        Done;
    logic [15:0] DIN;
    logic        Run;
    logic [4:0]  PC;
    logic        Busy;
    logic        Halted;
    logic        Err;

    int tests = 0;
    int fails = 0;

    instr_feeder dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .Stop   (Stop),
        .LdEn   (LdEn),
        .LdAddr (LdAddr),
        .LdData (LdData),
        .Done   (Done),
        .DIN    (DIN),
        .Run    (Run),
        .PC     (PC),
        .Busy   (Busy),
        .Halted (Halted),
        .Err    (Err)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] addr, input logic [15:0] data);
        LdEn   = 1'b1;
        LdAddr = addr;
        LdData = data;
        step();
        LdEn   = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0;
        Start  = 1'b0;
        Stop   = 1'b0;
        LdEn   = 1'b0;
        LdAddr = 5'd0;
        LdData = 16'h0000;
        Done   = 1'b0;
        step();
        step();
        chk("rst_din",    DIN,            16'h0000);
        chk("rst_run",    {15'd0, Run},   16'd0);
        chk("rst_pc",     {11'd0, PC},    16'd0);
        chk("rst_busy",   {15'd0, Busy},  16'd0);
        chk("rst_halted", {15'd0, Halted}, 16'd0);
        chk("rst_err",    {15'd0, Err},   16'd0);
        Resetn = 1'b1;
        step();

        // mvi R1,#5 then halt; Done raised during ISSUE must be ignored
        load(5'd0, 16'h0040);
        load(5'd1, 16'h0005);
        load(5'd2, 16'h01C0);
        pulse_start();
        chk("mvi_c1_din",  DIN,           16'h0040);
        chk("mvi_c1_busy", {15'd0, Busy}, 16'd1);
        Done = 1'b1;
        step();
        chk("mvi_c2_din", DIN,         16'h0005);
        chk("mvi_c2_pc",  {11'd0, PC}, 16'd1);
        step();
        Done = 1'b0;
        chk("mvi_c3_din", DIN,         16'h01C0);
        chk("mvi_c3_pc",  {11'd0, PC}, 16'd2);
        step();
        chk("halt_halted", {15'd0, Halted}, 16'd1);
        chk("halt_pc",     {11'd0, PC},     16'd2);
        chk("halt_run",    {15'd0, Run},    16'd0);
        chk("halt_din",    DIN,             16'h0000);
        chk("halt_busy",   {15'd0, Busy},   16'd0);

        // one-word add, Done three cycles after ISSUE; a load during WAIT is dropped
        load(5'd0, 16'h0080);
        load(5'd1, 16'h1234);
        pulse_start();
        chk("add_issue_din", DIN, 16'h0080);
        step();
        chk("add_w1_run", {15'd0, Run}, 16'd1);
        chk("add_w1_pc",  {11'd0, PC},  16'd1);
        chk("add_w1_din", DIN,          16'h0000);
        LdEn   = 1'b1;
        LdAddr = 5'd1;
        LdData = 16'hFFFF;
        step();
        LdEn = 1'b0;
        chk("add_w2_run", {15'd0, Run}, 16'd1);
        step();
        chk("add_w3_run", {15'd0, Run}, 16'd1);
        Done = 1'b1;
        step();
        Done = 1'b0;
        chk("add_next_pc",  {11'd0, PC},  16'd1);
        chk("add_next_din", DIN,          16'h1234);
        chk("add_next_run", {15'd0, Run}, 16'd1);

        // watchdog: no Done after a one-word instruction
        step();
        chk("wd_enter_pc", {11'd0, PC}, 16'd2);
        repeat (5) step();
        chk("wd_c5_err", {15'd0, Err}, 16'd0);
        step();
        chk("wd_c6_err",  {15'd0, Err},  16'd1);
        chk("wd_c6_run",  {15'd0, Run},  16'd0);
        chk("wd_c6_din",  DIN,           16'h0000);
        chk("wd_c6_busy", {15'd0, Busy}, 16'd0);

        // Stop during WAIT, then Start with a simultaneous load, then Start ignored while busy
        load(5'd0, 16'h0080);
        pulse_start();
        step();
        Stop = 1'b1;
        Done = 1'b1;
        step();
        Stop = 1'b0;
        Done = 1'b0;
        chk("stop_busy", {15'd0, Busy}, 16'd0);
        chk("stop_run",  {15'd0, Run},  16'd0);
        chk("stop_din",  DIN,           16'h0000);
        chk("stop_pc",   {11'd0, PC},   16'd1);
        LdEn   = 1'b1;
        LdAddr = 5'd0;
        LdData = 16'h0085;
        Start  = 1'b1;
        step();
        LdEn  = 1'b0;
        Start = 1'b0;
        chk("ldstart_din",  DIN,           16'h0085);
        chk("ldstart_pc",   {11'd0, PC},   16'd0);
        chk("ldstart_busy", {15'd0, Busy}, 16'd1);
        step();
        pulse_start();
        chk("busy_start_pc",  {11'd0, PC}, 16'd1);
        chk("busy_start_din", DIN,         16'h0000);
        Done = 1'b1;
        step();
        Done = 1'b0;
        chk("busy_start_next_din", DIN, 16'h1234);
        step();
        Stop = 1'b1;
        Done = 1'b1;
        step();
        Stop = 1'b0;
        Done = 1'b0;

        // reset during IMM
        load(5'd0, 16'h0040);
        load(5'd1, 16'h0007);
        load(5'd5, 16'hA5A5);
        pulse_start();
        step();
        chk("imm_din", DIN, 16'h0007);
        Resetn = 1'b0;
        #1;
        chk("rstimm_busy", {15'd0, Busy},   16'd0);
        chk("rstimm_pc",   {11'd0, PC},     16'd0);
        chk("rstimm_din",  DIN,             16'h0000);
        chk("rstimm_run",  {15'd0, Run},    16'd0);
        chk("rstimm_hlt",  {15'd0, Halted}, 16'd0);
        chk("rstimm_err",  {15'd0, Err},    16'd0);
        step();
        Resetn = 1'b1;
        step();

        // walk the whole memory to exercise PC wrap; mem[5] was kept across reset
        for (int i = 0; i < 32; i++) begin
            if (i != 5) begin
                load(5'(i), 16'h0080 + 16'(i));
            end
        end
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("walk_din_%0d", i), DIN, (i == 5) ? 16'hA5A5 : (16'h0080 + 16'(i)));
            step();
            Done = 1'b1;
            step();
            Done = 1'b0;
        end
        chk("wrap_pc",  {11'd0, PC}, 16'd0);
        chk("wrap_din", DIN,         16'h0080);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 Clock  input  1  system clock; all state changes on its rising edge.
REQ-002 Resetn  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  single-cycle pulse; begins execution at address 0.
REQ-004 Stop  input  1  level; the block finishes the current instruction, then goes to IDLE.
REQ-005 LdEn  input  1  program-memory write enable.
REQ-006 LdAddr  input  5  program-memory write address.
REQ-007 LdData  input  16  program-memory write data.
REQ-008 Done  input  1  instruction-complete strobe from the processor.
REQ-009 DIN  output  16  instruction or immediate word to the processor.
REQ-010 Run  output  1  high while the feeder is issuing or waiting on an instruction.
REQ-011 PC  output  5  address of the next memory word to present.
REQ-012 Busy  output  1  high in ISSUE, IMM and WAIT states.
REQ-013 Halted  output  1  high in HALT state.
REQ-014 Err  output  1  high in ERROR state.

Function
REQ-015 Program memory SHALL be 32 x 16 registers with a combinational read at PC.
REQ-016 Writes SHALL occur on the edge where LdEn=1 and Busy=0; LdEn SHALL be ignored while Busy=1.
REQ-017 Opcode SHALL be DIN[8:6]: 001 = mvi (two words), 111 = halt, anything else = one word.
REQ-018 States SHALL be IDLE, ISSUE, IMM, WAIT, HALT and ERROR.
REQ-019 IDLE: DIN=0 and Run=0; Start SHALL set PC<=0 and move to ISSUE.
REQ-020 ISSUE: DIN=mem[PC] and Run=1; at the edge, the next state SHALL be:
  - HALT if the opcode is 111; PC is held.
  - IMM if the opcode is 001; PC<=PC+1.
  - WAIT otherwise; PC<=PC+1.
REQ-021 IMM: DIN=mem[PC] (the immediate) and Run=1; at the edge PC<=PC+1. If Done=1, the next state SHALL be ISSUE, or IDLE if Stop=1. If Done=0, the next state SHALL be WAIT.
REQ-022 WAIT: DIN=0 and Run=1. Done=1 SHALL move to ISSUE, or to IDLE if Stop=1.
REQ-023 Watchdog: a 3-bit counter SHALL clear on entry to IMM or WAIT and increment each cycle in those states without Done; reaching 6 SHALL move to ERROR.
REQ-024 PC SHALL wrap from 31 to 0 with no flag.
REQ-025 HALT and ERROR states SHALL drive DIN=0 and Run=0; only Start SHALL leave them (PC<=0, go to ISSUE).
REQ-026 Start SHALL be ignored while Busy=1; Stop SHALL be ignored in IDLE, HALT and ERROR.
REQ-027 A Done pulse in ISSUE SHALL be ignored, because the processor cannot complete in its IR-load step.
REQ-028 A simultaneous Start and LdEn in IDLE SHALL perform the write, then start; the ISSUE cycle then sees the new word.
REQ-029 Busy, Halted and Err SHALL be registered-state decodes, mutually exclusive, and glitch-free relative to Clock.

Reset
REQ-030 While Resetn=0, the block SHALL hold: state=IDLE, PC=0, watchdog=0, DIN=0, Run=0, Busy=0, Halted=0, Err=0.
REQ-031 Program-memory contents SHALL be preserved across reset.
REQ-032 Reset asserted mid-instruction SHALL abort immediately, with no further memory write and no PC increment.

Verification
REQ-033 Load mem[0]=0x0040 (mvi R1), mem[1]=0x0005, mem[2]=0x01C0 (halt); pulse Start. Required:
  - Cycle 1: DIN=0x0040.
  - Cycle 2: DIN=0x0005; Done=1 here returns to ISSUE.
  - Cycle 3: DIN=0x01C0.
  - Then Halted=1 with PC=2.
REQ-034 Load mem[0]=0x0080 (add); return Done 3 cycles after ISSUE. Required: Run=1 throughout, PC=1 after Done, next ISSUE presents mem[1].
REQ-035 Load a one-word instruction and never assert Done. Required: Err=1 exactly 6 cycles after entering WAIT, with Run=0 and DIN=0.
REQ-036 Place a non-halt, one-word instruction at address 31 and start with PC=31. Required: after Done, PC=0 and ISSUE presents mem[0].
REQ-037 Hold Stop=1 during WAIT; Done arrives. Required: next state IDLE, Busy=0, and Start works afterwards.
REQ-038 Drop Resetn during IMM. Required: immediate return to IDLE, PC=0, all outputs 0; a memory word written before the reset reads back unchanged.
